// File: rtl/acc16_pkg.sv
// Shared state encoding and saturation constants for the
// acc16_sat frame accumulator.
package acc16_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/rca16_wof.sv
// 16-bit ripple-carry adder exposing carry-out and signed overflow
// (carry into the MSB xor carry out of the MSB).
module rca16_wof (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        c,
    output logic        ov
);

    logic [16:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c  = carry[16];
    assign ov = carry[15] ^ carry[16];

endmodule

// File: rtl/acc16_sat.sv
// Framed 16-bit signed accumulator with optional saturation,
// sticky overflow/carry flags and a saturating beat counter.
module acc16_sat
    import acc16_pkg::*;
#(
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_ov,
    output logic             out_cy,
    output logic [CNT_W-1:0] out_cnt
);

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic             ov_q, ov_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0] sum;
    logic        add_c;
    logic        add_ov;
    logic        accept;

    rca16_wof u_add (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .s   (sum),
        .c   (add_c),
        .ov  (add_ov)
    );

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ov_d    = ov_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            ov_d    = 1'b0;
            cy_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        // Clamp direction follows the sign of the running sum
                        if (SAT && add_ov) begin
                            acc_d = acc_q[15] ? SAT_NEG : SAT_POS;
                        end else begin
                            acc_d = sum;
                        end
                        ov_d = ov_q | add_ov;
                        cy_d = cy_q | add_c;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (in_last) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        ov_d    = 1'b0;
                        cy_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_sum = acc_q;
    assign out_ov  = ov_q;
    assign out_cy  = cy_q;
    assign out_cnt = cnt_q;

endmodule

// File: tb/tb_acc16_sat.sv
// Directed bench for acc16_sat: a saturating/8-bit-count instance and a
// wrapping/2-bit-count instance share one stimulus stream.
module tb_acc16_sat;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        clr;
    logic        out_ready;

    logic        in_ready, out_valid, out_ov, out_cy;
    logic [15:0] out_sum;
    logic [7:0]  out_cnt;

    logic        w_in_ready, w_out_valid, w_out_ov, w_out_cy;
    logic [15:0] w_out_sum;
    logic [1:0]  w_out_cnt;

    int checks;
    int failures;

    acc16_sat #(.SAT(1'b1), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ov    (out_ov),
        .out_cy    (out_cy),
        .out_cnt   (out_cnt)
    );

    acc16_sat #(.SAT(1'b0), .CNT_W(2)) dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_sum   (w_out_sum),
        .out_ov    (w_out_ov),
        .out_cy    (w_out_cy),
        .out_cnt   (w_out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; presents one beat for exactly one rising edge.
    task automatic beat(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0 1",
                     out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 16'h0 || out_cnt !== 8'd0 ||
            out_ov !== 1'b0 || out_cy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sum=%h cnt=%0d ov=%b cy=%b want 0",
                     out_sum, out_cnt, out_ov, out_cy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        beat(16'd3, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'd3) begin
            failures++;
            $display("FAIL basic_mid: valid=%b sum=%0d want 0 3",
                     out_valid, out_sum);
        end
        beat(16'd4, 1'b0);
        beat(16'd5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_hs: valid=%b ready=%b want 1 0",
                     out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 16'd12 || out_ov !== 1'b0 ||
            out_cy !== 1'b0 || out_cnt !== 8'd3) begin
            failures++;
            $display("FAIL basic_res: sum=%0d ov=%b cy=%b cnt=%0d want 12 0 0 3",
                     out_sum, out_ov, out_cy, out_cnt);
        end
        ack();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_ack: valid=%b sum=%h cnt=%0d want 0 0 0",
                     out_valid, out_sum, out_cnt);
        end
    endtask

    task automatic test_sat();
        beat(16'h7000, 1'b0);
        beat(16'h2000, 1'b1);
        checks++;
        if (out_sum !== 16'h7FFF || out_ov !== 1'b1 || out_cy !== 1'b0) begin
            failures++;
            $display("FAIL sat_pos: sum=%h ov=%b cy=%b want 7fff 1 0",
                     out_sum, out_ov, out_cy);
        end
        checks++;
        if (w_out_sum !== 16'h9000 || w_out_ov !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pos: sum=%h ov=%b want 9000 1",
                     w_out_sum, w_out_ov);
        end
        ack();
        beat(16'h8000, 1'b0);
        beat(16'hFFFF, 1'b1);
        checks++;
        if (out_sum !== 16'h8000 || out_ov !== 1'b1 || out_cy !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg: sum=%h ov=%b cy=%b want 8000 1 1",
                     out_sum, out_ov, out_cy);
        end
        checks++;
        if (w_out_sum !== 16'h7FFF || w_out_ov !== 1'b1) begin
            failures++;
            $display("FAIL wrap_neg: sum=%h ov=%b want 7fff 1",
                     w_out_sum, w_out_ov);
        end
        ack();
    endtask

    task automatic test_carry();
        beat(16'hFFFF, 1'b0);
        beat(16'h0001, 1'b1);
        checks++;
        if (out_sum !== 16'h0 || out_cy !== 1'b1 ||
            out_ov !== 1'b0 || out_cnt !== 8'd2) begin
            failures++;
            $display("FAIL carry: sum=%h cy=%b ov=%b cnt=%0d want 0 1 0 2",
                     out_sum, out_cy, out_ov, out_cnt);
        end
        ack();
    endtask

    task automatic test_back_to_back_hold();
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== 16'd3 || out_cnt !== 8'd2 ||
                out_ov !== 1'b0 || out_cy !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: valid=%b ready=%b sum=%0d cnt=%0d want 1 0 3 2",
                         i, out_valid, in_ready, out_sum, out_cnt);
            end
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
        ack();
        beat(16'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd7 || out_cnt !== 8'd1) begin
            failures++;
            $display("FAIL after_hold: valid=%b sum=%0d cnt=%0d want 1 7 1",
                     out_valid, out_sum, out_cnt);
        end
        ack();
    endtask

    task automatic test_clr();
        beat(16'd5, 1'b0);
        clr = 1'b1;
        beat(16'h0010, 1'b0);
        clr = 1'b0;
        checks++;
        if (out_sum !== 16'h0 || out_cnt !== 8'd0 ||
            out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_beat: sum=%h cnt=%0d valid=%b ready=%b want 0 0 0 1",
                     out_sum, out_cnt, out_valid, in_ready);
        end
        beat(16'd9, 1'b1);
        checks++;
        if (out_sum !== 16'd9 || out_cnt !== 8'd1) begin
            failures++;
            $display("FAIL clr_next: sum=%0d cnt=%0d want 9 1",
                     out_sum, out_cnt);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0) begin
            failures++;
            $display("FAIL clr_hold: valid=%b sum=%h want 0 0",
                     out_valid, out_sum);
        end
    endtask

    task automatic test_reset_mid();
        beat(16'd2, 1'b0);
        beat(16'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid: valid=%b sum=%h cnt=%0d want 0 0 0",
                     out_valid, out_sum, out_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(16'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd1 || out_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_next: valid=%b sum=%0d cnt=%0d want 1 1 1",
                     out_valid, out_sum, out_cnt);
        end
        ack();
    endtask

    task automatic test_cnt_sat();
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        beat(16'd1, 1'b1);
        checks++;
        if (out_cnt !== 8'd5 || out_sum !== 16'd5) begin
            failures++;
            $display("FAIL cnt_wide: cnt=%0d sum=%0d want 5 5",
                     out_cnt, out_sum);
        end
        checks++;
        if (w_out_cnt !== 2'd3 || w_out_sum !== 16'd5) begin
            failures++;
            $display("FAIL cnt_sat: cnt=%0d sum=%0d want 3 5",
                     w_out_cnt, w_out_sum);
        end
        ack();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sat();
        test_carry();
        test_back_to_back_hold();
        test_clr();
        test_reset_mid();
        test_cnt_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
